regression_accum: RTL and testbench

- Downstream consumer of the signed 14-bit fixed-point product stream from the regression multipliers.
- Accumulates a programmed number of products into a wide signed sum: Σxy, Σx² and similar terms for the regression solver.
- Presents the result both full-width and saturated back to 14 bits, under a valid/ready handshake, so it can feed the next multiplier stage directly.

---
 rtl/regression_accum.sv | 119 +++++++++++
 tb/tb_regression_accum.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regression_accum.sv
// Accumulates a programmed number of signed products into a wide sum and
// presents it full-width and saturated to DATA_W under a valid/ready handshake.
module regression_accum #(
   parameter int unsigned DATA_W    = 14,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned ACC_W     = 22,
   parameter int unsigned OUT_SHIFT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  n_samples,
   input  logic [DATA_W-1:0] prod_in,
   input  logic              prod_valid,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  sum_out,
   output logic [DATA_W-1:0] sum_sat,
   output logic              sat,
   output logic [CNT_W-1:0]  count_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam int unsigned EXT_W = ACC_W - DATA_W;
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(EXT_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_nxt;
   logic [CNT_W-1:0]         count;
   logic [CNT_W-1:0]         count_nxt;
   logic [CNT_W-1:0]         n_lat;
   logic [CNT_W-1:0]         n_lat_nxt;
   logic [CNT_W-1:0]         count_inc;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  shifted;

   assign prod_ext  = {{EXT_W{prod_in[DATA_W-1]}}, prod_in};
   assign count_inc = count + CNT_W'(1);

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
         n_lat <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
         n_lat <= n_lat_nxt;
      end
   end

   // Next-state, datapath update and handshake decode
   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      count_nxt  = count;
      n_lat_nxt  = n_lat;
      prod_ready = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               acc_nxt   = '0;
               count_nxt = '0;
               n_lat_nxt = n_samples;
               state_nxt = (n_samples == '0) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            prod_ready = 1'b1;
            busy       = 1'b1;
            if (prod_valid) begin
               acc_nxt   = acc + prod_ext;
               count_nxt = count_inc;
               if (count_inc == n_lat) state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign sum_out   = acc;
   assign count_out = count;
   assign shifted   = acc >>> OUT_SHIFT;

   // Clamp the shifted sum back into the signed DATA_W range
   always_comb begin
      sum_sat = shifted[DATA_W-1:0];
      sat     = 1'b0;
      if (shifted > SAT_MAX) begin
         sum_sat = SAT_MAX[DATA_W-1:0];
         sat     = 1'b1;
      end else if (shifted < SAT_MIN) begin
         sum_sat = SAT_MIN[DATA_W-1:0];
         sat     = 1'b1;
      end
   end

endmodule

// File: tb/tb_regression_accum.sv
// Table-driven bench for regression_accum plus hand-written multi-cycle sequences.
module tb_regression_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  n_samples;
   logic [13:0] prod_in;
   logic        prod_valid;
   logic        prod_ready;
   logic [21:0] sum_out;
   logic [13:0] sum_sat;
   logic        sat;
   logic [7:0]  count_out;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      int     n;
      int     p0, p1, p2, p3;
      bit     gap;
      int     hold;
      longint esum;
      int     esat_v;
      bit     esat;
      int     ecnt;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   regression_accum dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .n_samples  (n_samples),
      .prod_in    (prod_in),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .sum_out    (sum_out),
      .sum_sat    (sum_sat),
      .sat        (sat),
      .count_out  (count_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int pick(input vec_t v, input int i);
      case (i % 4)
         0: return v.p0;
         1: return v.p1;
         2: return v.p2;
         default: return v.p3;
      endcase
   endfunction

   // Called at a negedge in IDLE; returns at a negedge in IDLE
   task automatic run_vec(input vec_t v, input string tag);
      int  idx = 0;
      int  cyc = 0;
      bit  ph  = 1'b0;
      bit  rdy_ok = 1'b1;
      start     = 1'b1;
      n_samples = 8'(v.n);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy_in_accum"}, longint'(busy), 1);
      while (idx < v.n && cyc < 2000) begin
         if (!prod_ready) rdy_ok = 1'b0;
         prod_valid = v.gap ? ph : 1'b1;
         ph         = ~ph;
         prod_in    = 14'(pick(v, idx));
         @(posedge clk);
         if (prod_valid) idx++;
         cyc++;
         @(negedge clk);
      end
      prod_valid = 1'b0;
      chk({tag, " transfers_done"}, longint'(idx), longint'(v.n));
      chk({tag, " prod_ready_during_accum"}, longint'(rdy_ok), 1);
      chk({tag, " out_valid"}, longint'(out_valid), 1);
      chk({tag, " prod_ready_in_done"}, longint'(prod_ready), 0);
      chk({tag, " sum_out"}, longint'($signed(sum_out)), v.esum);
      chk({tag, " sum_sat"}, longint'($signed(sum_sat)), longint'(v.esat_v));
      chk({tag, " sat"}, longint'(sat), longint'(v.esat));
      chk({tag, " count_out"}, longint'(count_out), longint'(v.ecnt));
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk({tag, " hold_valid"}, longint'(out_valid), 1);
         chk({tag, " hold_ready_low"}, longint'(prod_ready), 0);
         chk({tag, " hold_sum"}, longint'($signed(sum_out)), v.esum);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " idle_valid_low"}, longint'(out_valid), 0);
      chk({tag, " idle_busy_low"}, longint'(busy), 0);
      chk({tag, " idle_sum_held"}, longint'($signed(sum_out)), v.esum);
   endtask

   initial begin
      vecs[0] = '{4, 100, -30, 8191, -8192, 1'b0, 0, 69, 69, 1'b0, 4};
      vecs[1] = '{4, 100, -30, 8191, -8192, 1'b1, 5, 69, 69, 1'b0, 4};
      vecs[2] = '{255, 8191, 8191, 8191, 8191, 1'b0, 0, 2088705, 8191, 1'b1, 255};
      vecs[3] = '{3, -8192, -8192, -8192, -8192, 1'b0, 0, -24576, -8192, 1'b1, 3};
      vecs[4] = '{2, 8190, 1, 0, 0, 1'b0, 0, 8191, 8191, 1'b0, 2};
      vecs[5] = '{2, 8191, 1, 0, 0, 1'b1, 0, 8192, 8191, 1'b1, 2};
      vecs[6] = '{2, -8191, -1, 0, 0, 1'b0, 0, -8192, -8192, 1'b0, 2};
      vecs[7] = '{2, -8192, -1, 0, 0, 1'b0, 0, -8193, -8192, 1'b1, 2};
      vecs[8] = '{1, -1, 0, 0, 0, 1'b0, 0, -1, -1, 1'b0, 1};

      rst_n = 1'b0; start = 1'b0; n_samples = '0; prod_in = '0;
      prod_valid = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset sum_out", longint'(sum_out), 0);
      chk("reset count_out", longint'(count_out), 0);
      chk("reset prod_ready", longint'(prod_ready), 0);
      chk("reset out_valid", longint'(out_valid), 0);
      chk("reset busy", longint'(busy), 0);
      chk("reset sat", longint'(sat), 0);
      chk("reset sum_sat", longint'(sum_sat), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Empty run: straight to DONE with a cleared sum
      start = 1'b1; n_samples = 8'd0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("empty out_valid", longint'(out_valid), 1);
      chk("empty prod_ready", longint'(prod_ready), 0);
      chk("empty sum_out", longint'(sum_out), 0);
      chk("empty count_out", longint'(count_out), 0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("empty back_to_idle", longint'(out_valid), 0);

      // start pulsed during ACCUM is ignored
      start = 1'b1; n_samples = 8'd2;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1; n_samples = 8'd9; prod_valid = 1'b1; prod_in = 14'(7);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; prod_in = 14'(-3);
      @(posedge clk);
      @(negedge clk);
      prod_valid = 1'b0;
      chk("ign_start out_valid", longint'(out_valid), 1);
      chk("ign_start count_out", longint'(count_out), 2);
      chk("ign_start sum_out", longint'($signed(sum_out)), 4);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;

      // Reset mid-run aborts asynchronously
      start = 1'b1; n_samples = 8'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; prod_valid = 1'b1; prod_in = 14'(100);
      @(posedge clk);
      @(negedge clk);
      prod_in = 14'(-30);
      @(posedge clk);
      @(negedge clk);
      prod_valid = 1'b0;
      chk("abort pre_count", longint'(count_out), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("abort sum_out", longint'(sum_out), 0);
      chk("abort count_out", longint'(count_out), 0);
      chk("abort prod_ready", longint'(prod_ready), 0);
      chk("abort busy", longint'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort idle_valid", longint'(out_valid), 0);
      run_vec('{2, 5, 6, 0, 0, 1'b0, 0, 11, 11, 1'b0, 2}, "fresh");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
